// File: rtl/l2_mem_responder_pkg.sv
// Shared L2 memory-interface types, AMO encodings and the responder FSM state type.
// Also provides the AMO result function used by the memory responder.
package l2_config_and_types;

  localparam int L2_ID_W      = 3;
  localparam int L2_SUB_ID_W  = 2;
  localparam int L2_PORT_ID_W = L2_ID_W - L2_SUB_ID_W;

  localparam logic [4:0] L2_AMO_ADD  = 5'b00000;
  localparam logic [4:0] L2_AMO_SWAP = 5'b00001;
  localparam logic [4:0] L2_AMO_LR   = 5'b00010;
  localparam logic [4:0] L2_AMO_SC   = 5'b00011;
  localparam logic [4:0] L2_AMO_XOR  = 5'b00100;
  localparam logic [4:0] L2_AMO_OR   = 5'b01000;
  localparam logic [4:0] L2_AMO_AND  = 5'b01100;
  localparam logic [4:0] L2_AMO_MIN  = 5'b10000;
  localparam logic [4:0] L2_AMO_MAX  = 5'b10100;
  localparam logic [4:0] L2_AMO_MINU = 5'b11000;
  localparam logic [4:0] L2_AMO_MAXU = 5'b11100;

  typedef struct packed {
    logic [31:0]        addr;
    logic               rnw;
    logic               is_amo;
    logic [4:0]         amo_type_or_burst_size;
    logic [L2_ID_W-1:0] id;
  } l2_mem_request_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
  } l2_data_request_t;

  typedef struct packed {
    logic [31:0]             data;
    logic [L2_PORT_ID_W-1:0] id;
    logic [L2_SUB_ID_W-1:0]  sub_id;
  } l2_mem_return_data_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    AMO_RD,
    AMO_WAIT,
    AMO_WR
  } l2_resp_state_t;

  // Value written back to memory; unknown encodings behave as SWAP.
  function automatic logic [31:0] l2_amo_result(input logic [4:0]  funct,
                                                input logic [31:0] old_val,
                                                input logic [31:0] operand);
    logic [31:0] res;
    case (funct)
      L2_AMO_ADD:  res = old_val + operand;
      L2_AMO_XOR:  res = old_val ^ operand;
      L2_AMO_OR:   res = old_val | operand;
      L2_AMO_AND:  res = old_val & operand;
      L2_AMO_MIN:  res = ($signed(old_val) < $signed(operand)) ? old_val : operand;
      L2_AMO_MAX:  res = ($signed(old_val) > $signed(operand)) ? old_val : operand;
      L2_AMO_MINU: res = (old_val < operand) ? old_val : operand;
      L2_AMO_MAXU: res = (old_val > operand) ? old_val : operand;
      default:     res = operand;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/l2_mem_responder_if.sv
// Arbiter-to-memory handshake bundle: request, write data and return channels.
interface l2_mem_responder_if;
  import l2_config_and_types::*;

  logic                req_valid;
  l2_mem_request_t     req;
  logic                req_pop;
  logic                wr_data_valid;
  l2_data_request_t    wr_data;
  logic                wr_data_pop;
  logic                rd_data_valid;
  l2_mem_return_data_t rd_data;
  logic                rd_data_ready;

  modport master (
    output req_valid, req, wr_data_valid, wr_data, rd_data_ready,
    input  req_pop, wr_data_pop, rd_data_valid, rd_data
  );

  modport slave (
    input  req_valid, req, wr_data_valid, wr_data, rd_data_ready,
    output req_pop, wr_data_pop, rd_data_valid, rd_data
  );

endinterface

// File: rtl/l2_mem_responder_return_buffer.sv
// Two-entry return FIFO; when empty a pushed word is presented in the same cycle
// so the RAM output register feeds the return channel without an extra stage.
module l2_return_buffer
  import l2_config_and_types::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  l2_mem_return_data_t push_data,
  input  logic                pop,
  output logic                valid,
  output l2_mem_return_data_t head,
  output logic [1:0]          count
);

  l2_mem_return_data_t slot [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          cnt;
  logic                store;
  logic                deq;

  // A word popped while bypassing never occupies a slot.
  assign store = push & ~(pop & (cnt == 2'd0));
  assign deq   = pop & (cnt != 2'd0);

  assign valid = (cnt != 2'd0) | push;
  assign head  = (cnt != 2'd0) ? slot[rd_ptr] : push_data;
  assign count = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      slot[0] <= '0;
      slot[1] <= '0;
    end else begin
      if (store) begin
        slot[wr_ptr] <= push_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + {1'b0, store} - {1'b0, deq};
    end
  end

endmodule

// File: rtl/l2_mem_responder.sv
// On-chip memory target for the L2 arbiter: services read bursts, write bursts
// and single-word AMOs against an inferred word-addressed RAM.
module l2_mem_responder
  import l2_config_and_types::*;
#(
  parameter int MEM_WORDS = 16384
)
(
  input  logic              clk,
  input  logic              rst_n,
  l2_mem_responder_if.slave mem
);

  // state    | meaning
  // IDLE     | waiting for a request
  // READ     | issuing burst reads, gated by return credit
  // WRITE    | popping and writing burst words
  // AMO_RD   | reading the AMO target word
  // AMO_WAIT | old value captured, waiting for operand and return slot
  // AMO_WR   | writing AMO result, queueing return value

  localparam int IDX_W = $clog2(MEM_WORDS);

  l2_resp_state_t          state_q, state_d;
  logic [IDX_W-1:0]        addr_q;
  logic [4:0]              left_q;
  logic [4:0]              funct_q;
  logic [L2_PORT_ID_W-1:0] tag_id_q;
  logic [L2_SUB_ID_W-1:0]  tag_sub_q;
  logic                    burst_pend_q;
  logic                    old_pend_q;
  logic                    old_got_q;
  logic                    ret_pend_q;
  logic [31:0]             ret_q;
  logic [31:0]             rd_q;
  logic [31:0]             ram [MEM_WORDS];

  logic                    req_pop;
  logic                    wr_data_pop;
  logic                    accept;
  logic                    step;
  logic                    ram_re;
  logic                    ram_we;
  logic [3:0]              ram_be;
  logic [31:0]             ram_wdata;
  logic                    ret_push;
  logic [31:0]             ret_val;
  logic                    have_old;
  logic                    last_word;
  logic [2:0]              occupancy;
  logic                    slot_ok;

  logic                    buf_push;
  l2_mem_return_data_t     buf_data;
  logic                    buf_pop;
  logic                    buf_valid;
  l2_mem_return_data_t     buf_head;
  logic [1:0]              buf_count;

  logic                    unused_addr_bits;
  assign unused_addr_bits = ^mem.req.addr[31:IDX_W];

  assign last_word = (left_q == 5'd0);
  assign have_old  = old_pend_q | old_got_q;

  // Words in flight from the RAM plus words queued must leave room for one more.
  assign occupancy = 3'(burst_pend_q) + 3'(ret_pend_q) + 3'(buf_count) - 3'(buf_pop);
  assign slot_ok   = (occupancy < 3'd2);

  always_comb begin
    state_d     = state_q;
    req_pop     = 1'b0;
    wr_data_pop = 1'b0;
    accept      = 1'b0;
    step        = 1'b0;
    ram_re      = 1'b0;
    ram_we      = 1'b0;
    ram_be      = 4'h0;
    ram_wdata   = mem.wr_data.data;
    ret_push    = 1'b0;
    ret_val     = rd_q;
    case (state_q)
      IDLE: begin
        if (mem.req_valid) begin
          req_pop = 1'b1;
          accept  = 1'b1;
          if (mem.req.is_amo)   state_d = AMO_RD;
          else if (mem.req.rnw) state_d = READ;
          else                  state_d = WRITE;
        end
      end
      READ: begin
        if (slot_ok) begin
          ram_re = 1'b1;
          step   = 1'b1;
          if (last_word) state_d = IDLE;
        end
      end
      WRITE: begin
        if (mem.wr_data_valid) begin
          wr_data_pop = 1'b1;
          ram_we      = 1'b1;
          ram_be      = mem.wr_data.be;
          step        = 1'b1;
          if (last_word) state_d = IDLE;
        end
      end
      AMO_RD: begin
        ram_re  = 1'b1;
        state_d = AMO_WAIT;
      end
      AMO_WAIT: begin
        if (have_old && slot_ok) begin
          if (funct_q == L2_AMO_LR) begin
            ret_push = 1'b1;
            state_d  = IDLE;
          end else if (mem.wr_data_valid) begin
            state_d = AMO_WR;
          end
        end
      end
      AMO_WR: begin
        if (mem.wr_data_valid) begin
          wr_data_pop = 1'b1;
          ram_we      = 1'b1;
          ram_be      = 4'hF;
          ram_wdata   = l2_amo_result(funct_q, rd_q, mem.wr_data.data);
          ret_push    = 1'b1;
          ret_val     = (funct_q == L2_AMO_SC) ? 32'h0 : rd_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      left_q       <= 5'd0;
      funct_q      <= 5'd0;
      tag_id_q     <= '0;
      tag_sub_q    <= '0;
      burst_pend_q <= 1'b0;
      old_pend_q   <= 1'b0;
      old_got_q    <= 1'b0;
      ret_pend_q   <= 1'b0;
      ret_q        <= 32'h0;
    end else begin
      state_q      <= state_d;
      burst_pend_q <= ram_re & (state_q == READ);
      old_pend_q   <= ram_re & (state_q == AMO_RD);
      old_got_q    <= (state_q == AMO_WAIT) & have_old;
      ret_pend_q   <= ret_push;
      if (ret_push) ret_q <= ret_val;
      if (accept) begin
        addr_q    <= mem.req.addr[IDX_W-1:0];
        left_q    <= mem.req.amo_type_or_burst_size;
        funct_q   <= mem.req.amo_type_or_burst_size;
        tag_id_q  <= mem.req.id[L2_ID_W-1:L2_SUB_ID_W];
        tag_sub_q <= mem.req.id[L2_SUB_ID_W-1:0];
      end else if (step) begin
        addr_q <= addr_q + 1'b1;
        left_q <= left_q - 1'b1;
      end
    end
  end

  // Single-port RAM: byte-enabled write, registered read; contents not reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) ram[addr_q][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
    if (ram_re) begin
      rd_q <= ram[addr_q];
    end
  end

  assign buf_push        = burst_pend_q | ret_pend_q;
  assign buf_data.data   = burst_pend_q ? rd_q : ret_q;
  assign buf_data.id     = tag_id_q;
  assign buf_data.sub_id = tag_sub_q;
  assign buf_pop         = buf_valid & mem.rd_data_ready;

  l2_return_buffer u_return_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_data (buf_data),
    .pop       (buf_pop),
    .valid     (buf_valid),
    .head      (buf_head),
    .count     (buf_count)
  );

  assign mem.req_pop       = req_pop;
  assign mem.wr_data_pop   = wr_data_pop;
  assign mem.rd_data_valid = buf_valid;
  assign mem.rd_data       = buf_head;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed bench for l2_mem_responder: bursts, partial writes, AMOs,
// return backpressure, address wrap and mid-burst reset.
module tb_l2_mem_responder;
  import l2_config_and_types::*;

  localparam int MW = 16384;

  logic clk;
  logic rst_n;
  l2_mem_responder_if bus ();

  l2_mem_responder #(.MEM_WORDS(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mem   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0]             got [64];
  logic [L2_PORT_ID_W-1:0] got_id;
  logic [L2_SUB_ID_W-1:0]  got_sub;
  int                      n_got, first_c, last_c, stab_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic send_req(input logic [31:0] addr, input logic rnw, input logic is_amo,
                          input logic [4:0] f, input logic [2:0] id);
    l2_mem_request_t r;
    int k;
    r = '0;
    r.addr = addr;
    r.rnw = rnw;
    r.is_amo = is_amo;
    r.amo_type_or_burst_size = f;
    r.id = id;
    bus.req = r;
    bus.req_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.req_pop && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("req_accept", 32'(bus.req_pop), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [4:0] bs,
                             input logic [31:0] data0, input logic [3:0] be);
    int k;
    send_req(addr, 1'b0, 1'b0, bs, 3'd0);
    for (int i = 0; i <= int'(bs); i++) begin
      bus.wr_data_valid = 1'b1;
      bus.wr_data.data = data0 + 32'(i);
      bus.wr_data.be = be;
      k = 0;
      @(negedge clk);
      while (!bus.wr_data_pop && k < 50) begin
        @(negedge clk);
        k++;
      end
      chk("wr_pop", 32'(bus.wr_data_pop), 32'd1);
      @(posedge clk);
      #1;
    end
    bus.wr_data_valid = 1'b0;
  endtask

  // mode 0: ready always 1; mode 1: ready pattern 1,0,0,1 repeating.
  task automatic read_burst(input logic [31:0] addr, input logic [4:0] bs,
                            input logic [2:0] id, input int mode);
    logic                stalled;
    l2_mem_return_data_t held;
    logic [3:0]          pat;
    pat = 4'b1001;
    for (int i = 0; i < 64; i++) got[i] = 32'hxxxx_xxxx;
    n_got = 0;
    first_c = -1;
    last_c = -1;
    stab_bad = 0;
    stalled = 1'b0;
    held = '0;
    got_id = 'x;
    got_sub = 'x;
    send_req(addr, 1'b1, 1'b0, bs, id);
    for (int c = 1; c <= 400 && n_got <= int'(bs); c++) begin
      bus.rd_data_ready = (mode == 0) ? 1'b1 : pat[3 - ((c - 1) % 4)];
      @(negedge clk);
      if (stalled && (!bus.rd_data_valid || bus.rd_data !== held)) stab_bad++;
      stalled = 1'b0;
      if (bus.rd_data_valid) begin
        if (bus.rd_data_ready) begin
          got[n_got] = bus.rd_data.data;
          if (n_got == 0) begin
            first_c = c;
            got_id = bus.rd_data.id;
            got_sub = bus.rd_data.sub_id;
          end
          last_c = c;
          n_got++;
        end else begin
          stalled = 1'b1;
          held = bus.rd_data;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.rd_data_ready = 1'b1;
  endtask

  task automatic amo(input logic [31:0] addr, input logic [4:0] f, input logic [31:0] operand,
                     output logic [31:0] ret, output int pop_c);
    logic got_ret;
    send_req(addr, 1'b0, 1'b1, f, 3'b010);
    bus.rd_data_ready = 1'b1;
    bus.wr_data_valid = (f != L2_AMO_LR);
    bus.wr_data.data = operand;
    bus.wr_data.be = 4'hF;
    ret = 32'hxxxx_xxxx;
    pop_c = -1;
    got_ret = 1'b0;
    for (int c = 1; c <= 50 && !got_ret; c++) begin
      @(negedge clk);
      if (bus.wr_data_pop) pop_c = c;
      if (bus.rd_data_valid) begin
        ret = bus.rd_data.data;
        got_ret = 1'b1;
      end
      @(posedge clk);
      #1;
      if (pop_c > 0) bus.wr_data_valid = 1'b0;
    end
    bus.wr_data_valid = 1'b0;
  endtask

  logic [31:0] amo_ret;
  int          amo_pop_c;
  int          bad;

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req = '0;
    bus.wr_data_valid = 1'b0;
    bus.wr_data = '0;
    bus.rd_data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_valid", 32'(bus.rd_data_valid), 32'd0);
    chk("reset_req_pop", 32'(bus.req_pop), 32'd0);
    chk("reset_wr_pop", 32'(bus.wr_data_pop), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write burst then read it back with tags and latency.
    write_burst(32'h10, 5'd3, 32'hA0, 4'hF);
    read_burst(32'h10, 5'd3, 3'b101, 0);
    chk("burst_count", 32'(n_got), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("burst_word%0d", i), got[i], 32'hA0 + 32'(i));
    chk("burst_id", 32'(got_id), 32'd1);
    chk("burst_sub_id", 32'(got_sub), 32'd1);
    chk("burst_first_latency", 32'(first_c), 32'd2);
    chk("burst_consecutive", 32'(last_c - first_c), 32'd3);

    // Partial byte write.
    write_burst(32'h40, 5'd0, 32'hFFFF_FFFF, 4'hF);
    write_burst(32'h40, 5'd0, 32'h0000_5500, 4'b0010);
    read_burst(32'h40, 5'd0, 3'd0, 0);
    chk("partial_write", got[0], 32'hFFFF_55FF);

    // AMOs.
    write_burst(32'h20, 5'd0, 32'd7, 4'hF);
    amo(32'h20, L2_AMO_ADD, 32'd5, amo_ret, amo_pop_c);
    chk("amo_add_ret", amo_ret, 32'd7);
    chk("amo_add_pop_cycle", 32'(amo_pop_c), 32'd3);
    read_burst(32'h20, 5'd0, 3'd0, 0);
    chk("amo_add_mem", got[0], 32'd12);
    amo(32'h20, L2_AMO_MIN, 32'hFFFF_FFFF, amo_ret, amo_pop_c);
    chk("amo_min_ret", amo_ret, 32'd12);
    read_burst(32'h20, 5'd0, 3'd0, 0);
    chk("amo_min_mem", got[0], 32'hFFFF_FFFF);
    amo(32'h20, L2_AMO_MINU, 32'd3, amo_ret, amo_pop_c);
    chk("amo_minu_ret", amo_ret, 32'hFFFF_FFFF);
    read_burst(32'h20, 5'd0, 3'd0, 0);
    chk("amo_minu_mem", got[0], 32'd3);
    amo(32'h20, L2_AMO_SC, 32'h55, amo_ret, amo_pop_c);
    chk("amo_sc_ret", amo_ret, 32'd0);
    amo(32'h20, L2_AMO_LR, 32'h0, amo_ret, amo_pop_c);
    chk("amo_lr_ret", amo_ret, 32'h55);
    read_burst(32'h20, 5'd0, 3'd0, 0);
    chk("amo_lr_no_write", got[0], 32'h55);

    // 32-word read under backpressure.
    write_burst(32'h100, 5'd31, 32'h1000, 4'hF);
    read_burst(32'h100, 5'd31, 3'd0, 1);
    chk("bp_count", 32'(n_got), 32'd32);
    bad = 0;
    for (int i = 0; i < 32; i++) if (got[i] !== 32'h1000 + 32'(i)) bad++;
    chk("bp_data_errors", 32'(bad), 32'd0);
    chk("bp_stability_errors", 32'(stab_bad), 32'd0);

    // Address wrap at the top of the RAM.
    write_burst(32'(MW - 2), 5'd3, 32'hB0, 4'hF);
    read_burst(32'(MW - 2), 5'd3, 3'd0, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_word%0d", i), got[i], 32'hB0 + 32'(i));
    read_burst(32'h0, 5'd0, 3'd0, 0);
    chk("wrap_index0", got[0], 32'hB2);
    read_burst(32'(MW + 1), 5'd0, 3'd0, 0);
    chk("upper_addr_ignored", got[0], 32'hB3);

    // Reset in the middle of a stalled read burst.
    bus.rd_data_ready = 1'b0;
    send_req(32'h100, 1'b1, 1'b0, 5'd31, 3'd0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("pre_reset_valid", 32'(bus.rd_data_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midburst_reset_valid", 32'(bus.rd_data_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.rd_data_ready = 1'b1;
    bus.req.rnw = 1'b1;
    bus.req.is_amo = 1'b0;
    bus.req_valid = 1'b1;
    #1;
    chk("post_reset_idle", 32'(bus.req_pop), 32'd1);
    bus.req_valid = 1'b0;
    read_burst(32'h10, 5'd0, 3'd0, 0);
    chk("post_reset_count", 32'(n_got), 32'd1);
    chk("post_reset_data", got[0], 32'hA0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_mem_responder.md
# l2_mem_responder

Memory-side endpoint of the L2 arbiter's memory interface. It accepts `l2_mem_request_t` requests and `l2_data_request_t` write words from the arbiter and services them against an internal word-addressed RAM. It returns read and AMO data as `l2_mem_return_data_t`, tagged with the originating port id and sub_id. It serves as the on-chip memory target for simulation and small FPGA builds.

## Interface

**Parameters**
- `MEM_WORDS`, default 16384: RAM depth in 32-bit words; power of two. Index width is `$clog2(MEM_WORDS)`.

**Ports**
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset. One clock domain.
- `req_valid` in 1: request available.
- `req` in `l2_mem_request_t`: addr (word address), rnw, is_amo, amo_type_or_burst_size, id.
- `req_pop` out 1: request consumed this cycle.
- `wr_data_valid` in 1: write/AMO data word available.
- `wr_data` in `l2_data_request_t`: data and be.
- `wr_data_pop` out 1: data word consumed this cycle.
- `rd_data_valid` out 1: return word valid.
- `rd_data` out `l2_mem_return_data_t`: return word and tags.
- `rd_data_ready` in 1: downstream accepts the return word.

## Operation

**Request decode**
- RAM index is `addr` modulo `MEM_WORDS`; upper address bits are ignored.
- Burst length is `amo_type_or_burst_size + 1` words, range 1..32, for non-AMO requests.
- Address increments by 1 per word and wraps modulo `MEM_WORDS`.
- Return tag: `rd_data.id = req.id[L2_ID_W-1:L2_SUB_ID_W]` and `rd_data.sub_id = req.id[L2_SUB_ID_W-1:0]`, latched at accept.

**FSM states:** IDLE, READ, WRITE, AMO_RD, AMO_WAIT, AMO_WR.
- **IDLE:** `req_pop`=1 when `req_valid`=1. Next state: is_amo → AMO_RD; else rnw → READ; else WRITE.
- **READ:** one RAM read is issued per cycle while the return-credit check passes. Credit check: `inflight + buffer_count - pop < 2`. Go to IDLE after the last read is issued.
- **WRITE:** each cycle with `wr_data_valid`=1, `wr_data_pop`=1 and the word is written with per-byte `be`. Go to IDLE after the last word.
- **AMO_RD:** issue one read of the target word.
- **AMO_WAIT:** hold until the old value is returned from the RAM.
  - LR has no data word: push the old value, go to IDLE.
  - All other AMOs need `wr_data_valid`=1 and a free return slot, then go to AMO_WR.
- **AMO_WR:** pop one data word, write the result with full byte enables, push the return value, go to IDLE.
  - Return value is the old value; SC returns 0.
  - Results by funct5: ADD sum; SWAP new value; SC new value, always succeeds; XOR/OR/AND bitwise; MIN/MAX signed compare; MINU/MAXU unsigned compare.
  - An unknown funct5 is treated as SWAP.
- Writes never produce a return word.
- Because the FSM is sequential, all of a request's RAM writes complete before the next request is accepted. No read-after-write hazard exists.

**Return buffer**
- 2-entry FIFO drives `rd_data_valid`/`rd_data` directly.
- `rd_data` must hold stable while `rd_data_valid`=1 and `rd_data_ready`=0.

## Timing

- Reset values: state IDLE, return buffer empty, `rd_data_valid`=0, `req_pop`=0, `wr_data_pop`=0. RAM contents are not reset.
- A reset asserted mid-burst abandons the burst. Words already written stay written.
- `req_pop` and `wr_data_pop` are combinational from the current state and valid inputs. They are never asserted without the matching valid.
- Read: accept in cycle N, RAM read in N+1, `rd_data_valid` in N+2.
  - With `rd_data_ready` held at 1, burst words are returned on consecutive cycles.
  - Backpressure stalls issue without loss or duplication.
- Write: one word per cycle. A new request can be accepted the cycle after the last word is popped.
- AMO: accept in N, old value available in N+2. Data pop, RAM write and return push occur in N+3 at the earliest.
- The RAM has a single port with a 1-cycle registered read and a byte-enabled write.

## Structure

- Add `L2_AMO_*` funct5 localparams to the shared `l2_config_and_types` package:
  - ADD 5'b00000, SWAP 00001, LR 00010, SC 00011, XOR 00100, OR 01000, AND 01100, MIN 10000, MAX 10100, MINU 11000, MAXU 11100.
- Sub-module `l2_return_buffer`: 2-entry FIFO of `l2_mem_return_data_t` with push, pop, count and valid.
- The RAM is inferred inline.

## Test plan

- Write burst addr 0x10, burst_size 3, data 0xA0..0xA3 with be 4'hF; then read burst addr 0x10, burst_size 3, id 3'b101 → returns 0xA0..0xA3 in order with id 1 and sub_id 1, on 4 consecutive cycles starting N+2.
- Partial write be 4'b0010 data 0x0000_5500 over 0xFFFF_FFFF; then single read → 0xFFFF_55FF.
- AMO ADD on a word holding 7 with operand 5 → returns 7, a later read returns 12. AMO MIN with 0xFFFF_FFFF → returns 12, a later read returns 0xFFFF_FFFF. MINU with 3 → returns 0xFFFF_FFFF, a later read returns 3.
- 32-word read with `rd_data_ready` toggling 1,0,0,1 repeatedly → exactly 32 words with correct data, and `rd_data` stable while stalled.
- Write burst at index `MEM_WORDS-2`, 4 words → indices `MEM_WORDS-2`, `MEM_WORDS-1`, 0 and 1 are written; readback matches.
- Deassert `rst_n` mid-read-burst → `rd_data_valid` drops immediately, FSM is in IDLE. A new request after reset is served normally.
